// File: rtl/interlock_sequencer_if.sv
// Airlock interlock signal bundle: request/occupancy inputs and door/pump status outputs.
// master = sequencer side, slave = occupancy block / supervisor side.
interface interlock_sequencer_if #(
   parameter int PRESS_WIDTH = 3
);
   logic                   arriving;
   logic                   departing;
   logic                   shipDocked;
   logic                   outerDoor;
   logic                   innerDoor;
   logic [PRESS_WIDTH-1:0] pressure;
   logic                   pumping;
   logic                   busy;
   logic                   doorTimeout;

   modport master (
      input  arriving, departing, shipDocked,
      output outerDoor, innerDoor, pressure, pumping, busy, doorTimeout
   );

   modport slave (
      output arriving, departing, shipDocked,
      input  outerDoor, innerDoor, pressure, pumping, busy, doorTimeout
   );
endinterface

// File: rtl/interlock_sequencer.sv
// Airlock door/pressure sequencer with registered (Moore) outputs.
// Optional door-wait abort enabled by defining INTERLOCK_DOOR_TIMEOUT_EN.
module interlock_sequencer #(
   parameter int PRESS_WIDTH    = 3,
   parameter int PRESS_MAX      = 7,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   interlock_sequencer_if.master bus
);
   localparam logic [PRESS_WIDTH-1:0] PMAX = PRESS_WIDTH'(PRESS_MAX);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      PUMP_DOWN  = 3'd1,
      PUMP_UP    = 3'd2,
      OUTER_OPEN = 3'd3,
      INNER_OPEN = 3'd4
   } state_t;

   state_t                 state_reg, state_next;
   logic                   dir_reg, dir_next;
   logic [PRESS_WIDTH-1:0] pressure_reg, pressure_next;
   logic                   outer_door_reg, inner_door_reg, pumping_reg, busy_reg;
   logic                   door_timeout_reg, door_timeout_next;
   logic                   door_wait;
   logic                   awaited;

`ifdef INTERLOCK_DOOR_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] wait_cnt_reg, wait_cnt_next;
`else
   logic unused_cfg;
   assign unused_cfg = (TIMEOUT_CYCLES != 0);
`endif

   always_comb begin
      state_next        = state_reg;
      dir_next          = dir_reg;
      pressure_next     = pressure_reg;
      door_timeout_next = 1'b0;
      door_wait         = 1'b0;
      awaited           = 1'b0;
      case (state_reg)
         IDLE: begin
            if (bus.departing) begin
               dir_next   = 1'b1;
               state_next = (pressure_reg == PMAX) ? INNER_OPEN : PUMP_UP;
            end else if (bus.arriving) begin
               dir_next   = 1'b0;
               state_next = (pressure_reg == '0) ? OUTER_OPEN : PUMP_DOWN;
            end
         end
         PUMP_DOWN: begin
            // Saturate at vacuum; the door opens on the edge that reaches 0.
            if (pressure_reg <= PRESS_WIDTH'(1)) begin
               pressure_next = '0;
               state_next    = OUTER_OPEN;
            end else begin
               pressure_next = pressure_reg - PRESS_WIDTH'(1);
            end
         end
         PUMP_UP: begin
            if (pressure_reg >= PMAX - PRESS_WIDTH'(1)) begin
               pressure_next = PMAX;
               state_next    = INNER_OPEN;
            end else begin
               pressure_next = pressure_reg + PRESS_WIDTH'(1);
            end
         end
         OUTER_OPEN: begin
            door_wait = 1'b1;
            awaited   = dir_reg ? !bus.shipDocked : bus.shipDocked;
            if (awaited) state_next = dir_reg ? IDLE : PUMP_UP;
         end
         INNER_OPEN: begin
            door_wait = 1'b1;
            awaited   = dir_reg ? bus.shipDocked : !bus.shipDocked;
            if (awaited) state_next = dir_reg ? PUMP_DOWN : IDLE;
         end
         default: state_next = IDLE;
      endcase

`ifdef INTERLOCK_DOOR_TIMEOUT_EN
      // A timeout only fires when the awaited level is absent on that edge.
      if (door_wait && !awaited && (wait_cnt_reg == TLAST)) begin
         state_next        = IDLE;
         door_timeout_next = 1'b1;
      end
      wait_cnt_next = (door_wait && (state_next == state_reg)) ? wait_cnt_reg + TW'(1) : '0;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg        <= IDLE;
         dir_reg          <= 1'b0;
         pressure_reg     <= PMAX;
         outer_door_reg   <= 1'b0;
         inner_door_reg   <= 1'b0;
         pumping_reg      <= 1'b0;
         busy_reg         <= 1'b0;
         door_timeout_reg <= 1'b0;
`ifdef INTERLOCK_DOOR_TIMEOUT_EN
         wait_cnt_reg     <= '0;
`endif
      end else begin
         state_reg        <= state_next;
         dir_reg          <= dir_next;
         pressure_reg     <= pressure_next;
         outer_door_reg   <= (state_next == OUTER_OPEN);
         inner_door_reg   <= (state_next == INNER_OPEN);
         pumping_reg      <= (state_next == PUMP_DOWN) || (state_next == PUMP_UP);
         busy_reg         <= (state_next != IDLE);
         door_timeout_reg <= door_timeout_next;
`ifdef INTERLOCK_DOOR_TIMEOUT_EN
         wait_cnt_reg     <= wait_cnt_next;
`endif
      end
   end

   assign bus.outerDoor   = outer_door_reg;
   assign bus.innerDoor   = inner_door_reg;
   assign bus.pressure    = pressure_reg;
   assign bus.pumping     = pumping_reg;
   assign bus.busy        = busy_reg;
   assign bus.doorTimeout = door_timeout_reg;
endmodule

// File: tb/tb_interlock_sequencer.sv
// Self-checking bench for interlock_sequencer: vector table plus hand-written corner sequences,
// with a per-cycle safety monitor on the door/pressure invariants.
module tb_interlock_sequencer;
   localparam int PW   = 3;
   localparam int PMAX = 7;
   localparam int TOUT = 16;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   mon_en   = 1'b0;

   interlock_sequencer_if #(.PRESS_WIDTH(PW)) bus();

   interlock_sequencer #(
      .PRESS_WIDTH(PW), .PRESS_MAX(PMAX), .TIMEOUT_CYCLES(TOUT)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus.master)
   );

   always #5 clock = ~clock;

   typedef struct {
      string name;
      logic  rst, arr, dep, ship;
      logic  e_outer, e_inner;
      int    e_press;
      logic  e_pump, e_busy, e_tout;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic void add(string n, logic rst, logic arr, logic dep, logic ship,
                               logic eo, logic ei, int ep, logic epump, logic ebusy, logic eto);
      vec_t v;
      v.name = n; v.rst = rst; v.arr = arr; v.dep = dep; v.ship = ship;
      v.e_outer = eo; v.e_inner = ei; v.e_press = ep;
      v.e_pump = epump; v.e_busy = ebusy; v.e_tout = eto;
      vecs.push_back(v);
   endfunction

   always @(negedge clock) begin
      if (mon_en) begin
         n_checks++;
         if (bus.outerDoor && (int'(bus.pressure) != 0)) begin
            n_fail++;
            $display("FAIL inv_outer: outerDoor=1 with pressure %0d, required 0", bus.pressure);
         end
         if (bus.innerDoor && (int'(bus.pressure) != PMAX)) begin
            n_fail++;
            $display("FAIL inv_inner: innerDoor=1 with pressure %0d, required %0d", bus.pressure, PMAX);
         end
         if (bus.outerDoor && bus.innerDoor) begin
            n_fail++;
            $display("FAIL inv_both: both doors open, required at most one");
         end
      end
   end

   initial begin
      int cyc;
      int highs;
      bit seen_to;

      bus.arriving = 1'b0; bus.departing = 1'b0; bus.shipDocked = 1'b0;

      // Arrival from reset: pump 7->0, outer, pump 0->7, inner, idle
      add("reset",      1,0,0,0, 0,0,7,   0,0,0);
      add("arr_req",    0,1,0,0, 0,0,7,   1,1,0);
      for (int i = 1; i <= 6; i++) add("arr_pump_dn", 0,0,0,0, 0,0,7-i, 1,1,0);
      add("arr_outer",  0,0,0,0, 1,0,0,   0,1,0);
      add("arr_owait",  0,0,0,0, 1,0,0,   0,1,0);
      add("arr_ship_in",0,0,0,1, 0,0,0,   1,1,0);
      for (int i = 1; i <= 6; i++) add("arr_pump_up", 0,0,0,1, 0,0,i, 1,1,0);
      add("arr_inner",  0,0,0,1, 0,1,7,   0,1,0);
      add("arr_iwait",  0,0,0,1, 0,1,7,   0,1,0);
      add("arr_left",   0,0,0,0, 0,0,7,   0,0,0);
      add("idle_hold",  0,0,0,0, 0,0,7,   0,0,0);
      // Departure at base pressure: inner opens after one edge
      add("dep_req",    0,0,1,0, 0,1,7,   0,1,0);
      add("dep_iwait",  0,0,0,0, 0,1,7,   0,1,0);
      add("dep_ship_in",0,0,0,1, 0,0,7,   1,1,0);
      for (int i = 1; i <= 6; i++) add("dep_pump_dn", 0,0,0,1, 0,0,7-i, 1,1,0);
      add("dep_outer",  0,0,0,1, 1,0,0,   0,1,0);
      add("dep_owait",  0,0,0,1, 1,0,0,   0,1,0);
      add("dep_out",    0,0,0,0, 0,0,0,   0,0,0);
      // Arrival already at vacuum: outer opens after one edge
      add("vac_arr",    0,1,0,0, 1,0,0,   0,1,0);
      add("vac_ship_in",0,0,0,1, 0,0,0,   1,1,0);
      for (int i = 1; i <= 6; i++) add("vac_pump_up", 0,0,0,1, 0,0,i, 1,1,0);
      add("vac_inner",  0,0,0,1, 0,1,7,   0,1,0);
      add("vac_left",   0,0,0,0, 0,0,7,   0,0,0);
      // Both requests: departure wins; requests during pump-down ignored
      add("both_req",   0,1,1,0, 0,1,7,   0,1,0);
      add("both_ship",  0,0,0,1, 0,0,7,   1,1,0);
      add("both_dn6",   0,0,0,1, 0,0,6,   1,1,0);
      add("req_ignored",0,1,1,1, 0,0,5,   1,1,0);
      for (int i = 3; i <= 6; i++) add("both_pump_dn", 0,0,0,1, 0,0,7-i, 1,1,0);
      add("both_outer", 0,0,0,1, 1,0,0,   0,1,0);
      add("both_out",   0,0,0,0, 0,0,0,   0,0,0);

      foreach (vecs[i]) begin
         reset          = vecs[i].rst;
         bus.arriving   = vecs[i].arr;
         bus.departing  = vecs[i].dep;
         bus.shipDocked = vecs[i].ship;
         step();
         mon_en = 1'b1;
         chk($sformatf("%s[%0d].outer", vecs[i].name, i), int'(bus.outerDoor),   int'(vecs[i].e_outer));
         chk($sformatf("%s[%0d].inner", vecs[i].name, i), int'(bus.innerDoor),   int'(vecs[i].e_inner));
         chk($sformatf("%s[%0d].press", vecs[i].name, i), int'(bus.pressure),    vecs[i].e_press);
         chk($sformatf("%s[%0d].pump",  vecs[i].name, i), int'(bus.pumping),     int'(vecs[i].e_pump));
         chk($sformatf("%s[%0d].busy",  vecs[i].name, i), int'(bus.busy),        int'(vecs[i].e_busy));
         chk($sformatf("%s[%0d].tout",  vecs[i].name, i), int'(bus.doorTimeout), int'(vecs[i].e_tout));
         $display("vec %0d %s: outer=%0b inner=%0b press=%0d pump=%0b busy=%0b",
                  i, vecs[i].name, bus.outerDoor, bus.innerDoor, bus.pressure, bus.pumping, bus.busy);
      end
      bus.arriving = 1'b0; bus.departing = 1'b0; bus.shipDocked = 1'b0;

      // Reset in PUMP_UP at pressure 3 (state is IDLE at vacuum here)
      bus.arriving = 1'b1; step(); bus.arriving = 1'b0;
      bus.shipDocked = 1'b1; step();
      step(); step(); step();
      chk("mid_pumpup.press", int'(bus.pressure), 3);
      chk("mid_pumpup.pump",  int'(bus.pumping), 1);
      reset = 1'b1; bus.shipDocked = 1'b0; step(); reset = 1'b0;
      chk("mid_reset.press", int'(bus.pressure), PMAX);
      chk("mid_reset.doors", int'({bus.outerDoor, bus.innerDoor}), 0);
      chk("mid_reset.busy",  int'(bus.busy), 0);
      chk("mid_reset.pump",  int'(bus.pumping), 0);
      $display("seq reset_in_pump_up: press=%0d busy=%0b", bus.pressure, bus.busy);

      // Full arrival with shipDocked following the doors immediately
      bus.arriving = 1'b1; step(); bus.arriving = 1'b0;
      cyc = 1;
      while (bus.busy && cyc < 50) begin
         if (bus.outerDoor) bus.shipDocked = 1'b1;
         if (bus.innerDoor) bus.shipDocked = 1'b0;
         step();
         cyc++;
      end
      chk("full_cycle.edges", cyc, 2*PMAX + 3);
      chk("full_cycle.press", int'(bus.pressure), PMAX);
      $display("seq full_arrival: %0d edges request to idle", cyc);

      // Arrival with shipDocked held low: door wait limit
      bus.shipDocked = 1'b0;
      bus.arriving = 1'b1; step(); bus.arriving = 1'b0;
      cyc = 1;
      while (!bus.outerDoor && cyc < 20) begin step(); cyc++; end
      chk("wait_outer.edges", cyc, PMAX + 1);
      highs = 0; seen_to = 1'b0;
      while (bus.outerDoor && highs < 40) begin
         if (bus.doorTimeout) seen_to = 1'b1;
         highs++;
         step();
      end
`ifdef INTERLOCK_DOOR_TIMEOUT_EN
      chk("tout.outer_high", highs, TOUT);
      chk("tout.early_pulse", int'(seen_to), 0);
      chk("tout.pulse",   int'(bus.doorTimeout), 1);
      chk("tout.busy",    int'(bus.busy), 0);
      chk("tout.press",   int'(bus.pressure), 0);
      chk("tout.outer",   int'(bus.outerDoor), 0);
      step();
      chk("tout.pulse_end", int'(bus.doorTimeout), 0);
      $display("seq timeout: outer high %0d cycles, idle at press=%0d", highs, bus.pressure);
`else
      chk("no_tout.outer_high", highs, 40);
      chk("no_tout.pulse", int'(seen_to | bus.doorTimeout), 0);
      chk("no_tout.busy",  int'(bus.busy), 1);
      $display("seq no_timeout: outer still open after %0d cycles", highs);
      reset = 1'b1; step(); reset = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
